// File: rtl/csa_accumulator.sv
// csa_accumulator: carry-save operand accumulator feeding a downstream carry-propagate adder
module csa_accumulator #(
  parameter int N = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  a_out,
  output logic [N-1:0]  b_out,
  output logic          cin_out,
  output logic          add_en,
  output logic          ovf,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;
  state_t state, next;
  logic [LW-1:0] cnt;
  logic [N-1:0] maj;
  logic hs;
  assign hs = state == ACCUM && in_valid;
  assign maj = a_out & b_out | a_out & in_data | b_out & in_data;
  assign in_ready = state == ACCUM;
  assign add_en = state == FLUSH;
  assign done = state == DONE;
  assign busy = state != IDLE;
  assign cin_out = 1'b0;
  always_comb begin
    next = state;
    case (state)
      IDLE:  next = start ? (len != '0 ? ACCUM : FLUSH) : IDLE;
      ACCUM: next = hs && cnt == LW'(1) ? FLUSH : ACCUM;
      FLUSH: next = DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_out <= '0;
      b_out <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        a_out <= '0;
        b_out <= '0;
        ovf <= 1'b0;
        cnt <= len;
      end else if (hs) begin
        a_out <= a_out ^ b_out ^ in_data;
        b_out <= {maj[N-2:0], 1'b0};
        ovf <= ovf | maj[N-1];
        cnt <= cnt - LW'(1);
      end
    end
  end
endmodule

// File: tb/tb_csa_accumulator.sv
// tb_csa_accumulator: scoreboard bench for csa_accumulator with directed vectors
module tb_csa_accumulator;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [3:0] len = 0;
  logic [7:0] in_data = 0;
  logic in_ready, cin_out, add_en, ovf, busy, done;
  logic [7:0] a_out, b_out;
  int checks = 0, fails = 0, cyc = 0;
  logic prev_add_en = 0;
  logic [7:0] ops [8];
  typedef struct {
    logic [7:0] sum;
    logic ov;
    int at;
  } exp_t;
  exp_t q[$];

  csa_accumulator #(.N(8), .LW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .a_out(a_out), .b_out(b_out),
    .cin_out(cin_out), .add_en(add_en), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] s;
    exp_t e;
    if (done) begin
      s = {1'b0, a_out} + {1'b0, b_out};
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("sum", s[7:0], e.sum);
        chk("overflow", ovf | s[8], e.ov);
        chk("latency", cyc, e.at);
        chk("add_en_before_done", prev_add_en, 1);
        chk("cin_out", cin_out, 0);
      end
    end
    prev_add_en <= add_en;
  end

  task automatic run(input int n, input int stall_at, input int stalls, input bit restart,
                     input logic [7:0] sum, input logic ov);
    exp_t e;
    @(negedge clk);
    start = 1;
    len = 4'(n);
    @(posedge clk);
    #1;
    start = 0;
    len = 4'hf;
    e.sum = sum;
    e.ov = ov;
    e.at = cyc + n + 1 + stalls;
    q.push_back(e);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        in_valid = 0;
        for (int k = 0; k < stalls; k++) begin
          @(posedge clk);
          #1;
          chk("ready_held_in_stall", in_ready, 1);
        end
      end
      in_valid = 1;
      in_data = ops[i];
      if (restart && i == 1) begin
        start = 1;
        len = 4'd1;
      end
      @(posedge clk);
      #1;
      start = 0;
    end
    in_valid = 0;
    for (int t = 0; t < 20 && q.size() != 0; t++) @(posedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", 0, 1);
      q.delete();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, in_ready, add_en, done, ovf, cin_out}, 0);
    chk("reset_a_b", {a_out, b_out}, 0);
    rst = 0;
    ops[0] = 10; ops[1] = 20; ops[2] = 30;
    run(3, -1, 0, 0, 8'd60, 0);
    for (int i = 0; i < 4; i++) ops[i] = 8'hff;
    run(4, -1, 0, 0, 8'hfc, 1);
    ops[0] = 8'h05; ops[1] = 8'h03;
    run(2, 1, 3, 0, 8'h08, 0);
    run(0, -1, 0, 0, 8'h00, 0);
    chk("len0_a_b_zero", {a_out, b_out}, 0);
    for (int i = 0; i < 3; i++) ops[i] = 100;
    run(3, -1, 0, 1, 8'h2c, 1);
    @(negedge clk);
    start = 1;
    len = 5;
    @(posedge clk);
    #1;
    start = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1;
      in_data = 8'h11;
      @(posedge clk);
      #1;
    end
    rst = 1;
    start = 1;
    @(posedge clk);
    #1;
    rst = 0;
    start = 0;
    in_valid = 0;
    chk("abort_outputs", {busy, in_ready, add_en, done, ovf, cin_out}, 0);
    chk("abort_a_b", {a_out, b_out}, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_idle", busy, 0);
    ops[0] = 8'h80; ops[1] = 8'h7f;
    run(2, -1, 0, 0, 8'hff, 0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
